// File: rtl/adder_axi_master_if.sv
// Bundle of the request/response handshake ports and the AXI4-Lite master
// channels used between adder_axi_master and its downstream adder slave.
// The master modport is the view seen by adder_axi_master; the slave modport
// is the view of whatever sits on the other side.
interface adder_axi_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    // Request / response side
    logic                    req_valid;
    logic                    req_ready;
    logic [DATA_WIDTH-1:0]   req_a;
    logic [DATA_WIDTH-1:0]   req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_sum;
    logic [1:0]              rsp_err;

    // AXI4-Lite write address / data / response channels
    logic [ADDR_WIDTH-1:0]   m0_axi_awaddr;
    logic                    m0_axi_awvalid;
    logic                    m0_axi_awready;
    logic [DATA_WIDTH-1:0]   m0_axi_wdata;
    logic [DATA_WIDTH/8-1:0] m0_axi_wstrb;
    logic                    m0_axi_wvalid;
    logic                    m0_axi_wready;
    logic [1:0]              m0_axi_bresp;
    logic                    m0_axi_bvalid;
    logic                    m0_axi_bready;

    // AXI4-Lite read address / data channels
    logic [ADDR_WIDTH-1:0]   m0_axi_araddr;
    logic                    m0_axi_arvalid;
    logic                    m0_axi_arready;
    logic [DATA_WIDTH-1:0]   m0_axi_rdata;
    logic [1:0]              m0_axi_rresp;
    logic                    m0_axi_rvalid;
    logic                    m0_axi_rready;

    modport master (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_err,
        output m0_axi_awaddr, m0_axi_awvalid,
        input  m0_axi_awready,
        output m0_axi_wdata, m0_axi_wstrb, m0_axi_wvalid,
        input  m0_axi_wready,
        input  m0_axi_bresp, m0_axi_bvalid,
        output m0_axi_bready,
        output m0_axi_araddr, m0_axi_arvalid,
        input  m0_axi_arready,
        input  m0_axi_rdata, m0_axi_rresp, m0_axi_rvalid,
        output m0_axi_rready
    );

    modport slave (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_err,
        input  m0_axi_awaddr, m0_axi_awvalid,
        output m0_axi_awready,
        input  m0_axi_wdata, m0_axi_wstrb, m0_axi_wvalid,
        output m0_axi_wready,
        output m0_axi_bresp, m0_axi_bvalid,
        input  m0_axi_bready,
        input  m0_axi_araddr, m0_axi_arvalid,
        output m0_axi_arready,
        output m0_axi_rdata, m0_axi_rresp, m0_axi_rvalid,
        input  m0_axi_rready
    );
endinterface

// File: rtl/adder_axi_master.sv
// AXI4-Lite master for the memory-mapped adder: writes operand A, then
// operand B, reads back the result register and returns it on the response
// port. One transaction in flight; every output comes straight from a flop.
// Optional per-phase watchdog: define ADDER_AXI_MASTER_TIMEOUT_EN to enable.
module adder_axi_master #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 8,
    parameter logic [ADDR_WIDTH-1:0] A_ADDR         = 8'h00,
    parameter logic [ADDR_WIDTH-1:0] B_ADDR         = 8'h04,
    parameter logic [ADDR_WIDTH-1:0] R_ADDR         = 8'h08,
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic            m0_axi_aclk,
    input  logic            m0_axi_areset,
    adder_axi_master_if.master bus
);

    localparam int SW = DATA_WIDTH / 8;
    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_SLAVE = 2'b01;

    typedef enum logic [2:0] {
        IDLE, WR_A, WB_A, WR_B, WB_B, RD_AR, RD_R, RESP
    } state_e;

    state_e                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic [1:0]            rsp_err_q, rsp_err_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         wstrb_q, wstrb_d;
    // Operand A goes straight into wdata at acceptance, so only B needs a holding register.
    logic [DATA_WIDTH-1:0] b_q, b_d;

    // A channel counts as finished once its valid is low (already handshaken) or is handshaking now.
    logic aw_done, w_done;
    assign aw_done = !awvalid_q || bus.m0_axi_awready;
    assign w_done  = !wvalid_q  || bus.m0_axi_wready;

`ifdef ADDER_AXI_MASTER_TIMEOUT_EN
    localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    ERR_TIMEOUT = 2'b10;

    logic [TW-1:0] timer_q, timer_d;
    logic          busy, timeout_hit;
    assign busy        = (state_q != IDLE) && (state_q != RESP);
    assign timeout_hit = busy && (timer_q == TIMER_LAST);
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // Next-state and next-output logic; each branch sets up the outputs for the state being entered.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_err_d   = rsp_err_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        b_d         = b_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    state_d     = WR_A;
                    req_ready_d = 1'b0;
                    b_d         = bus.req_b;
                    awvalid_d   = 1'b1;
                    wvalid_d    = 1'b1;
                    awaddr_d    = A_ADDR;
                    wdata_d     = bus.req_a;
                    wstrb_d     = '1;
                end
            end
            WR_A, WR_B: begin
                awvalid_d = awvalid_q && !bus.m0_axi_awready;
                wvalid_d  = wvalid_q  && !bus.m0_axi_wready;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    if (state_q == WR_A) begin
                        state_d = WB_A;
                    end else begin
                        state_d = WB_B;
                    end
                end
            end
            WB_A, WB_B: begin
                if (bus.m0_axi_bvalid) begin
                    bready_d = 1'b0;
                    if (bus.m0_axi_bresp != 2'b00) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_sum_d   = '0;
                        rsp_err_d   = ERR_SLAVE;
                    end else if (state_q == WB_A) begin
                        state_d   = WR_B;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = B_ADDR;
                        wdata_d   = b_q;
                    end else begin
                        state_d   = RD_AR;
                        arvalid_d = 1'b1;
                        araddr_d  = R_ADDR;
                    end
                end
            end
            RD_AR: begin
                if (bus.m0_axi_arready) begin
                    state_d   = RD_R;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_R: begin
                if (bus.m0_axi_rvalid) begin
                    state_d     = RESP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (bus.m0_axi_rresp == 2'b00) begin
                        rsp_sum_d = bus.m0_axi_rdata;
                        rsp_err_d = ERR_OK;
                    end else begin
                        rsp_sum_d = '0;
                        rsp_err_d = ERR_SLAVE;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef ADDER_AXI_MASTER_TIMEOUT_EN
        if (timeout_hit) begin
            state_d     = RESP;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_sum_d   = '0;
            rsp_err_d   = ERR_TIMEOUT;
        end
        if ((state_d != state_q) || !busy) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end
`endif
    end

    // State and registered outputs; reset aborts any transaction without a response.
    always_ff @(posedge m0_axi_aclk or posedge m0_axi_areset) begin
        if (m0_axi_areset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_err_q   <= ERR_OK;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            b_q         <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_err_q   <= rsp_err_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            b_q         <= b_d;
        end
    end

`ifdef ADDER_AXI_MASTER_TIMEOUT_EN
    // Per-phase watchdog counter, restarted on every state change.
    always_ff @(posedge m0_axi_aclk or posedge m0_axi_areset) begin
        if (m0_axi_areset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    assign bus.req_ready      = req_ready_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_sum        = rsp_sum_q;
    assign bus.rsp_err        = rsp_err_q;
    assign bus.m0_axi_awaddr  = awaddr_q;
    assign bus.m0_axi_awvalid = awvalid_q;
    assign bus.m0_axi_wdata   = wdata_q;
    assign bus.m0_axi_wstrb   = wstrb_q;
    assign bus.m0_axi_wvalid  = wvalid_q;
    assign bus.m0_axi_bready  = bready_q;
    assign bus.m0_axi_araddr  = araddr_q;
    assign bus.m0_axi_arvalid = arvalid_q;
    assign bus.m0_axi_rready  = rready_q;

endmodule

// File: tb/tb_adder_axi_master.sv
// Directed testbench for adder_axi_master with a small AXI4-Lite adder slave
// model whose ready timing and response codes are steered by knobs.
module tb_adder_axi_master;

    logic clk;
    logic rst;
    int   pass_count;
    int   check_count;

    adder_axi_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

    adder_axi_master #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8),
        .A_ADDR(8'h00), .B_ADDR(8'h04), .R_ADDR(8'h08),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .m0_axi_aclk  (clk),
        .m0_axi_areset(rst),
        .bus          (bus)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave knobs and observation logs
    logic [3:0]  aw_delay;
    logic [1:0]  bresp_knob;
    logic [1:0]  rresp_knob;
    logic        ar_en;
    logic        clear_log;
    logic [3:0]  aw_wait;
    logic        have_aw, have_w, rd_pend;
    logic [7:0]  pend_addr;
    logic [31:0] pend_data;
    logic [31:0] reg_a, reg_b;
    logic [2:0]  wr_count, rd_count;
    logic [7:0]  wr_addr_log [0:7];
    logic [31:0] wr_data_log [0:7];
    logic [7:0]  rd_addr_log;

    assign bus.m0_axi_wready  = bus.m0_axi_wvalid;
    assign bus.m0_axi_awready = bus.m0_axi_awvalid && (aw_wait >= aw_delay);
    assign bus.m0_axi_bvalid  = bus.m0_axi_bready && have_aw && have_w;
    assign bus.m0_axi_bresp   = bresp_knob;
    assign bus.m0_axi_arready = bus.m0_axi_arvalid && ar_en;
    assign bus.m0_axi_rvalid  = bus.m0_axi_rready && rd_pend;
    assign bus.m0_axi_rdata   = reg_a + reg_b;
    assign bus.m0_axi_rresp   = rresp_knob;

    // Slave model: accepts writes to A/B, returns A+B on reads, logs traffic
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            have_aw <= 1'b0;
            have_w  <= 1'b0;
            rd_pend <= 1'b0;
            aw_wait <= 4'd0;
        end else begin
            if (bus.m0_axi_awvalid && !bus.m0_axi_awready) aw_wait <= aw_wait + 4'd1;
            else aw_wait <= 4'd0;
            if (bus.m0_axi_awvalid && bus.m0_axi_awready) begin
                pend_addr <= bus.m0_axi_awaddr;
                have_aw   <= 1'b1;
            end
            if (bus.m0_axi_wvalid && bus.m0_axi_wready) begin
                pend_data <= bus.m0_axi_wdata;
                have_w    <= 1'b1;
            end
            if (bus.m0_axi_bvalid && bus.m0_axi_bready) begin
                have_aw <= 1'b0;
                have_w  <= 1'b0;
                wr_addr_log[wr_count] <= pend_addr;
                wr_data_log[wr_count] <= pend_data;
                wr_count <= wr_count + 3'd1;
                if (bresp_knob == 2'b00) begin
                    if (pend_addr == 8'h00) reg_a <= pend_data;
                    else if (pend_addr == 8'h04) reg_b <= pend_data;
                end
            end
            if (bus.m0_axi_arvalid && bus.m0_axi_arready) begin
                rd_pend     <= 1'b1;
                rd_addr_log <= bus.m0_axi_araddr;
                rd_count    <= rd_count + 3'd1;
            end
            if (bus.m0_axi_rvalid && bus.m0_axi_rready) rd_pend <= 1'b0;
            if (clear_log) begin
                wr_count <= 3'd0;
                rd_count <= 3'd0;
            end
        end
    end

    // Clears the slave traffic log while the master is idle
    task automatic clear_slave_log();
        @(negedge clk); clear_log = 1'b1;
        @(negedge clk); clear_log = 1'b0;
    endtask

    // Presents a request and returns at the negedge of the first cycle after its handshake
    task automatic send_req(input logic [31:0] a, input logic [31:0] b, output bit ok);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_a = a; bus.req_b = b;
        n = 0;
        while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
        ok = bus.req_ready;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Counts cycles (from 1 at the current negedge) until rsp_valid, bounded
    task automatic wait_rsp(output int n);
        n = 1;
        while (!bus.rsp_valid && n < 200) begin @(negedge clk); n++; end
    endtask

    // Completes the response handshake, returning at the negedge after it
    task automatic take_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_count++; if (bus.req_ready !== 1'b1) $display("[TB] FAIL rst_req_ready: got %b want 1", bus.req_ready); else pass_count++;
        check_count++; if ({bus.rsp_valid, bus.rsp_err} !== 3'b000) $display("[TB] FAIL rst_rsp: got %b want 000", {bus.rsp_valid, bus.rsp_err}); else pass_count++;
        check_count++; if (bus.rsp_sum !== 32'd0) $display("[TB] FAIL rst_rsp_sum: got %0h want 0", bus.rsp_sum); else pass_count++;
        check_count++; if ({bus.m0_axi_awvalid, bus.m0_axi_wvalid, bus.m0_axi_bready, bus.m0_axi_arvalid, bus.m0_axi_rready} !== 5'b00000) $display("[TB] FAIL rst_axi_ctl: got %b want 00000", {bus.m0_axi_awvalid, bus.m0_axi_wvalid, bus.m0_axi_bready, bus.m0_axi_arvalid, bus.m0_axi_rready}); else pass_count++;
        check_count++; if ({bus.m0_axi_awaddr, bus.m0_axi_araddr, bus.m0_axi_wdata, bus.m0_axi_wstrb} !== 52'd0) $display("[TB] FAIL rst_axi_data: got %h want 0", {bus.m0_axi_awaddr, bus.m0_axi_araddr, bus.m0_axi_wdata, bus.m0_axi_wstrb}); else pass_count++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_wait();
        bit ok; int n;
        $display("[TB] test_zero_wait");
        clear_slave_log();
        send_req(32'd5, 32'd7, ok);
        check_count++; if (!ok) $display("[TB] FAIL zw_accept: got 0 want 1"); else pass_count++;
        check_count++; if ({bus.m0_axi_awvalid, bus.m0_axi_wvalid, bus.m0_axi_awaddr, bus.m0_axi_wdata, bus.m0_axi_wstrb} !== {1'b1, 1'b1, 8'h00, 32'd5, 4'hF}) $display("[TB] FAIL zw_wr_a: got %h want %h", {bus.m0_axi_awvalid, bus.m0_axi_wvalid, bus.m0_axi_awaddr, bus.m0_axi_wdata, bus.m0_axi_wstrb}, {1'b1, 1'b1, 8'h00, 32'd5, 4'hF}); else pass_count++;
        wait_rsp(n);
        check_count++; if (n !== 7) $display("[TB] FAIL zw_latency: got %0d want 7", n); else pass_count++;
        check_count++; if (bus.rsp_sum !== 32'd12) $display("[TB] FAIL zw_sum: got %0d want 12", bus.rsp_sum); else pass_count++;
        check_count++; if (bus.rsp_err !== 2'b00) $display("[TB] FAIL zw_err: got %b want 00", bus.rsp_err); else pass_count++;
        take_rsp();
        check_count++; if (bus.req_ready !== 1'b1) $display("[TB] FAIL zw_req_ready_back: got %b want 1", bus.req_ready); else pass_count++;
        check_count++; if (wr_count !== 3'd2) $display("[TB] FAIL zw_wr_count: got %0d want 2", wr_count); else pass_count++;
        check_count++; if ({wr_addr_log[0], wr_data_log[0]} !== {8'h00, 32'd5}) $display("[TB] FAIL zw_write0: got %h want %h", {wr_addr_log[0], wr_data_log[0]}, {8'h00, 32'd5}); else pass_count++;
        check_count++; if ({wr_addr_log[1], wr_data_log[1]} !== {8'h04, 32'd7}) $display("[TB] FAIL zw_write1: got %h want %h", {wr_addr_log[1], wr_data_log[1]}, {8'h04, 32'd7}); else pass_count++;
        check_count++; if ({rd_count, rd_addr_log} !== {3'd1, 8'h08}) $display("[TB] FAIL zw_read: got %h want %h", {rd_count, rd_addr_log}, {3'd1, 8'h08}); else pass_count++;
    endtask

    task automatic test_slave_error();
        bit ok; int n;
        $display("[TB] test_slave_error");
        clear_slave_log();
        bresp_knob = 2'b10;
        send_req(32'd20, 32'd22, ok);
        check_count++; if (!ok) $display("[TB] FAIL berr_accept: got 0 want 1"); else pass_count++;
        wait_rsp(n);
        check_count++; if (n !== 3) $display("[TB] FAIL berr_latency: got %0d want 3", n); else pass_count++;
        check_count++; if (bus.rsp_err !== 2'b01) $display("[TB] FAIL berr_err: got %b want 01", bus.rsp_err); else pass_count++;
        check_count++; if (bus.rsp_sum !== 32'd0) $display("[TB] FAIL berr_sum: got %0d want 0", bus.rsp_sum); else pass_count++;
        take_rsp();
        check_count++; if ({wr_count, rd_count} !== {3'd1, 3'd0}) $display("[TB] FAIL berr_traffic: got wr=%0d rd=%0d want wr=1 rd=0", wr_count, rd_count); else pass_count++;
        bresp_knob = 2'b00;
    endtask

    task automatic test_aw_delay();
        bit ok; int n;
        $display("[TB] test_aw_delay");
        clear_slave_log();
        aw_delay = 4'd3;
        send_req(32'hFFFF_FFFF, 32'd1, ok);
        check_count++; if (!ok) $display("[TB] FAIL awd_accept: got 0 want 1"); else pass_count++;
        @(negedge clk);
        check_count++; if ({bus.m0_axi_awvalid, bus.m0_axi_wvalid} !== 2'b10) $display("[TB] FAIL awd_independent: got %b want 10", {bus.m0_axi_awvalid, bus.m0_axi_wvalid}); else pass_count++;
        wait_rsp(n);
        n = n + 1;
        check_count++; if (n !== 13) $display("[TB] FAIL awd_latency: got %0d want 13", n); else pass_count++;
        check_count++; if ({bus.rsp_err, bus.rsp_sum} !== {2'b00, 32'd0}) $display("[TB] FAIL awd_rsp: got err=%b sum=%0h want err=00 sum=0", bus.rsp_err, bus.rsp_sum); else pass_count++;
        take_rsp();
        check_count++; if ({wr_addr_log[0], wr_data_log[0], wr_addr_log[1], wr_data_log[1]} !== {8'h00, 32'hFFFF_FFFF, 8'h04, 32'd1}) $display("[TB] FAIL awd_writes: got %h want %h", {wr_addr_log[0], wr_data_log[0], wr_addr_log[1], wr_data_log[1]}, {8'h00, 32'hFFFF_FFFF, 8'h04, 32'd1}); else pass_count++;
        aw_delay = 4'd0;
    endtask

    task automatic test_back_to_back();
        bit ok; int n;
        $display("[TB] test_back_to_back");
        send_req(32'd3, 32'd4, ok);
        check_count++; if (!ok) $display("[TB] FAIL b2b_accept1: got 0 want 1"); else pass_count++;
        bus.req_valid = 1'b1; bus.req_a = 32'd10; bus.req_b = 32'd20;
        wait_rsp(n);
        check_count++; if (n !== 7) $display("[TB] FAIL b2b_latency1: got %0d want 7", n); else pass_count++;
        for (int i = 0; i < 4; i++) begin
            check_count++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_sum, bus.req_ready} !== {1'b1, 2'b00, 32'd7, 1'b0}) $display("[TB] FAIL b2b_hold%0d: got %h want %h", i, {bus.rsp_valid, bus.rsp_err, bus.rsp_sum, bus.req_ready}, {1'b1, 2'b00, 32'd7, 1'b0}); else pass_count++;
            @(negedge clk);
        end
        take_rsp();
        check_count++; if (bus.req_ready !== 1'b1) $display("[TB] FAIL b2b_req_ready: got %b want 1", bus.req_ready); else pass_count++;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_count++; if (bus.req_ready !== 1'b0) $display("[TB] FAIL b2b_accept2: got %b want 0", bus.req_ready); else pass_count++;
        wait_rsp(n);
        check_count++; if (n !== 7) $display("[TB] FAIL b2b_latency2: got %0d want 7", n); else pass_count++;
        check_count++; if (bus.rsp_sum !== 32'd30) $display("[TB] FAIL b2b_sum2: got %0d want 30", bus.rsp_sum); else pass_count++;
        take_rsp();
    endtask

    task automatic test_rresp_error();
        bit ok; int n;
        $display("[TB] test_rresp_error");
        rresp_knob = 2'b10;
        send_req(32'd1, 32'd1, ok);
        check_count++; if (!ok) $display("[TB] FAIL rerr_accept: got 0 want 1"); else pass_count++;
        wait_rsp(n);
        check_count++; if (n !== 7) $display("[TB] FAIL rerr_latency: got %0d want 7", n); else pass_count++;
        check_count++; if ({bus.rsp_err, bus.rsp_sum} !== {2'b01, 32'd0}) $display("[TB] FAIL rerr_rsp: got err=%b sum=%0h want err=01 sum=0", bus.rsp_err, bus.rsp_sum); else pass_count++;
        take_rsp();
        rresp_knob = 2'b00;
    endtask

    task automatic test_reset_mid();
        bit ok; int n;
        $display("[TB] test_reset_mid");
        send_req(32'd100, 32'd200, ok);
        check_count++; if (!ok) $display("[TB] FAIL rmid_accept: got 0 want 1"); else pass_count++;
        repeat (3) @(negedge clk);
        check_count++; if (bus.m0_axi_bready !== 1'b1) $display("[TB] FAIL rmid_in_wb_b: got %b want 1", bus.m0_axi_bready); else pass_count++;
        rst = 1'b1;
        #1;
        check_count++; if ({bus.m0_axi_awvalid, bus.m0_axi_wvalid, bus.m0_axi_bready, bus.m0_axi_arvalid, bus.m0_axi_rready, bus.rsp_valid, bus.req_ready} !== 7'b0000001) $display("[TB] FAIL rmid_abort: got %b want 0000001", {bus.m0_axi_awvalid, bus.m0_axi_wvalid, bus.m0_axi_bready, bus.m0_axi_arvalid, bus.m0_axi_rready, bus.rsp_valid, bus.req_ready}); else pass_count++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_count++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) $display("[TB] FAIL rmid_no_rsp%0d: got %b want 01", i, {bus.rsp_valid, bus.req_ready}); else pass_count++;
        end
        send_req(32'd9, 32'd6, ok);
        check_count++; if (!ok) $display("[TB] FAIL rmid_accept2: got 0 want 1"); else pass_count++;
        wait_rsp(n);
        check_count++; if (n !== 7) $display("[TB] FAIL rmid_latency: got %0d want 7", n); else pass_count++;
        check_count++; if ({bus.rsp_err, bus.rsp_sum} !== {2'b00, 32'd15}) $display("[TB] FAIL rmid_rsp: got err=%b sum=%0d want err=00 sum=15", bus.rsp_err, bus.rsp_sum); else pass_count++;
        take_rsp();
    endtask

`ifdef ADDER_AXI_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok; int hi;
        $display("[TB] test_timeout");
        ar_en = 1'b0;
        send_req(32'd2, 32'd3, ok);
        check_count++; if (!ok) $display("[TB] FAIL to_accept: got 0 want 1"); else pass_count++;
        hi = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.m0_axi_arvalid) hi++;
            else if (hi > 0) break;
            @(negedge clk);
        end
        check_count++; if (hi !== 16) $display("[TB] FAIL to_arvalid_cycles: got %0d want 16", hi); else pass_count++;
        check_count++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_sum, bus.m0_axi_arvalid} !== {1'b1, 2'b10, 32'd0, 1'b0}) $display("[TB] FAIL to_rsp: got %h want %h", {bus.rsp_valid, bus.rsp_err, bus.rsp_sum, bus.m0_axi_arvalid}, {1'b1, 2'b10, 32'd0, 1'b0}); else pass_count++;
        take_rsp();
        ar_en = 1'b1;
    endtask
`endif

    // Test sequence
    initial begin
        pass_count = 0;
        check_count = 0;
        rst = 1'b1;
        aw_delay = 4'd0; bresp_knob = 2'b00; rresp_knob = 2'b00; ar_en = 1'b1; clear_log = 1'b0;
        wr_count = 3'd0; rd_count = 3'd0; reg_a = 32'd0; reg_b = 32'd0;
        bus.req_valid = 1'b0; bus.req_a = 32'd0; bus.req_b = 32'd0; bus.rsp_ready = 1'b0;
        test_reset();
        test_zero_wait();
        test_slave_error();
        test_aw_delay();
        test_back_to_back();
        test_rresp_error();
        test_reset_mid();
`ifdef ADDER_AXI_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/adder_axi_master.md
# adder_axi_master

AXI4-Lite master that drives the memory-mapped adder slave directly downstream of it. It accepts one operand pair on a valid/ready request port and writes operand A, then operand B, into the slave. It then reads back the result register and returns the sum with a status code on a valid/ready response port. It sits between the command/control logic and the adder's s0_axi port, with one transaction in flight at a time.

## Interface
- DATA_WIDTH, 32: operand, AXI data and sum width; wstrb width is DATA_WIDTH/8.
- ADDR_WIDTH, 8: AXI address width.
- A_ADDR, 8'h00: byte address of the operand A register.
- B_ADDR, 8'h04: byte address of the operand B register.
- R_ADDR, 8'h08: byte address of the result register.
- TIMEOUT_CYCLES, 255: per-phase watchdog limit; used only when the macro is defined.
- m0_axi_aclk  in  1  sole clock; all logic is on its rising edge.
- m0_axi_areset  in  1  asynchronous, active-high reset.
- req_valid, req_ready  in/out  1 each  request handshake.
- req_a, req_b  in  DATA_WIDTH each  operands, captured at the request handshake.
- rsp_valid, rsp_ready  out/in  1 each  response handshake.
- rsp_sum  out  DATA_WIDTH  result read from R_ADDR.
- rsp_err  out  2  status: 00 OK, 01 slave error, 10 timeout.
- m0_axi_awaddr/awvalid/awready  out/out/in  ADDR_WIDTH/1/1  write address channel.
- m0_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- m0_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel.
- m0_axi_araddr/arvalid/arready  out/out/in  ADDR_WIDTH/1/1  read address channel.
- m0_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA_WIDTH/2/1/1  read data channel.

## Operation
- Moore FSM with the following states and transitions:
  - IDLE → WR_A on req_valid & req_ready.
  - WR_A → WB_A.
  - WB_A → WR_B.
  - WR_B → WB_B.
  - WB_B → RD_AR.
  - RD_AR → RD_R.
  - RD_R → RESP.
  - RESP → IDLE on rsp_valid & rsp_ready.
- req_ready=1 only in IDLE. Operands are latched into internal registers at the request handshake.
- WR_A / WR_B:
  - awvalid and wvalid are both asserted; wstrb is all ones.
  - awaddr is A_ADDR or B_ADDR; wdata is the latched A or B.
  - Each valid drops independently in the cycle after its own handshake.
  - The state advances once both AW and W have completed, in either order or in the same cycle.
- WB_A / WB_B: bready=1; the state advances on bvalid.
- RD_AR: arvalid=1 with araddr=R_ADDR; the state advances on arready.
- RD_R: rready=1; on rvalid, rdata is captured into rsp_sum.
- Errors:
  - Any bresp≠00 skips all remaining phases and goes to RESP with rsp_err=01, rsp_sum=0.
  - rresp≠00 gives rsp_err=01, rsp_sum=0.
- RESP: rsp_valid=1. rsp_sum and rsp_err stay stable until rsp_ready.
- Sum arithmetic is done by the slave; this block performs no arithmetic and no width change.
- A req_valid arriving while the block is busy is held off by req_ready=0 and is never dropped.

## Timing
- Reset values: req_ready=1; rsp_valid=0; rsp_sum=0; rsp_err=00; all AXI valids and readys are 0; awaddr=araddr=0; wdata=0; wstrb=0; FSM in IDLE.
- Reset asserted mid-transaction returns the FSM to IDLE immediately and drops all valids. No response is issued for the aborted request.
- All outputs are registered. A valid, once raised, is never withdrawn before its handshake, except by reset or timeout.
- Minimum latency, with a slave that responds in the same cycle:
  - rsp_valid is high in the 7th cycle after the request handshake edge.
  - One cycle is spent in each of WR_A, WB_A, WR_B, WB_B, RD_AR and RD_R.
- Back-to-back operation: req_ready returns high in the cycle after the rsp handshake.

## Configuration
- ADDER_AXI_MASTER_TIMEOUT_EN defined:
  - A counter, cleared on every state change, counts cycles spent in each non-IDLE, non-RESP state.
  - On reaching TIMEOUT_CYCLES, all AXI valids and readys drop and the FSM goes to RESP with rsp_err=10, rsp_sum=0.
- ADDER_AXI_MASTER_TIMEOUT_EN undefined: no counter exists; the block waits indefinitely and rsp_err=10 never occurs.

## Test plan
- Zero-wait slave; req_a=5, req_b=7 → writes 5@0x00, then 7@0x04, then reads 0x08; rsp_sum=12, rsp_err=00, rsp_valid in the 7th cycle.
- Slave with awready 3 cycles after wready; A=32'hFFFF_FFFF, B=1 → AW and W complete independently; rsp_sum=0 (slave wrap), rsp_err=00.
- bresp=2'b10 on the operand A write → no B write and no read are issued; rsp_err=01, rsp_sum=0.
- rsp_ready held low for 4 cycles while a second req_valid is pending → rsp fields stable, req_ready=0; the second request is accepted in the cycle after the rsp handshake.
- Reset asserted while in WB_B → all valids are 0 in the next cycle, FSM in IDLE, no rsp_valid; a subsequent request completes normally.
- With the macro defined and TIMEOUT_CYCLES=16, slave never asserts arready → arvalid drops after 16 cycles in RD_AR; rsp_err=10, rsp_sum=0.
